// File: rtl/rotate_amount_finder_32.sv
// rotate_amount_finder_32
//
// Purpose: given an original word and a rotated word, find the smallest
// rotate amount k (0..31) such that rotating originalData by k in the selected
// direction reproduces rotatedData. The search runs as one candidate per
// clock cycle. A request is accepted only from IDLE, and the result is held
// in DONE until it is consumed.
//
// Ports:
//   clk                       rising-edge clock
//   rst_n                     synchronous active-low reset
//   inValid / inReady         request handshake (inReady high only in IDLE)
//   sel_left_or_right_rotate  1 = right rotate, 0 = left rotate
//   originalData              unrotated 32-bit word
//   rotatedData               32-bit word to explain as a rotation
//   outValid / outReady       result handshake
//   found                     1 = a matching shift exists
//   shiftVal                  smallest matching shift (0 when found = 0)
//
// Configuration macro:
//   ROT_FIND_EARLY_EXIT_EN  when defined, the search stops at the first match.
//                           When it is undefined, the search always evaluates
//                           all 32 candidates and has constant latency.

module rotate_amount_finder_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inValid,
  output logic        inReady,
  input  logic        sel_left_or_right_rotate,
  input  logic [31:0] originalData,
  input  logic [31:0] rotatedData,
  output logic        outValid,
  input  logic        outReady,
  output logic        found,
  output logic [4:0]  shiftVal
);

  localparam int DATA_W  = 32;
  localparam int SHIFT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t               state, stateNext;
  logic [DATA_W-1:0]    capOrig;
  logic [DATA_W-1:0]    capRot;
  logic                 capDir;
  logic [SHIFT_W-1:0]   cand;
  logic                 foundReg;
  logic [SHIFT_W-1:0]   shiftReg;
  logic                 candMatch;
  logic                 lastCand;
  logic                 acceptFire;

  // A shift by 32 yields zero, so the k = 0 case falls out as w | 0 = w.
  function automatic logic [DATA_W-1:0] rotateWord(input logic [DATA_W-1:0]  w,
                                                   input logic [SHIFT_W-1:0] s,
                                                   input logic               right);
    logic [SHIFT_W:0] comp;
    comp = 6'd32 - {1'b0, s};
    if (right) rotateWord = (w >> s) | (w << comp);
    else       rotateWord = (w << s) | (w >> comp);
  endfunction

  assign candMatch  = (rotateWord(capOrig, cand, capDir) == capRot);
  assign lastCand   = (cand == 5'd31);
  assign acceptFire = inValid && inReady;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    inReady   = 1'b0;
    outValid  = 1'b0;
    case (state)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) stateNext = SEARCH;
      end
      SEARCH: begin
        if (lastCand) stateNext = DONE;
`ifdef ROT_FIND_EARLY_EXIT_EN
        if (candMatch) stateNext = DONE;
`endif
      end
      DONE: begin
        outValid = 1'b1;
        if (outReady) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Capture on accept, then scan candidates. The first match sets the result,
  // and later matches cannot replace it. The counter stops at 31 and does not wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      capOrig  <= '0;
      capRot   <= '0;
      capDir   <= 1'b0;
      cand     <= '0;
      foundReg <= 1'b0;
      shiftReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acceptFire) begin
            capOrig  <= originalData;
            capRot   <= rotatedData;
            capDir   <= sel_left_or_right_rotate;
            cand     <= '0;
            foundReg <= 1'b0;
            shiftReg <= '0;
          end
        end
        SEARCH: begin
          if (candMatch && !foundReg) begin
            foundReg <= 1'b1;
            shiftReg <= cand;
          end
          if (!lastCand) cand <= cand + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign found    = foundReg;
  assign shiftVal = shiftReg;

endmodule

// File: tb/tb_rotate_amount_finder_32.sv
module tb_rotate_amount_finder_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic        sel_left_or_right_rotate;
  logic [31:0] originalData;
  logic [31:0] rotatedData;
  logic        outValid;
  logic        outReady;
  logic        found;
  logic [4:0]  shiftVal;

  int errors = 0;
  int checks = 0;

`ifdef ROT_FIND_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  rotate_amount_finder_32 dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .inValid                  (inValid),
    .inReady                  (inReady),
    .sel_left_or_right_rotate (sel_left_or_right_rotate),
    .originalData             (originalData),
    .rotatedData              (rotatedData),
    .outValid                 (outValid),
    .outReady                 (outReady),
    .found                    (found),
    .shiftVal                 (shiftVal)
  );

  // Reference model: each output bit is picked directly by its index.
  function automatic logic [31:0] modelRot(input logic [31:0] w, input int k, input logic right);
    logic [31:0] r;
    for (int i = 0; i < 32; i++)
      r[i] = right ? w[(i + k) % 32] : w[(i - k + 32) % 32];
    return r;
  endfunction

  function automatic void modelFind(input logic [31:0] o, input logic [31:0] r, input logic right,
                                    output logic f, output logic [4:0] s, output int lat);
    f = 1'b0;
    s = 5'd0;
    for (int k = 0; k < 32; k++)
      if (!f && modelRot(o, k, right) == r) begin
        f = 1'b1;
        s = 5'(k);
      end
    lat = (EARLY && f) ? int'(s) + 1 : 32;
  endfunction

  // Issue one request. Record when the result appears and what it is, then consume it.
  // Input data are scrambled after the accept edge so that they can be shown to have no effect.
  task automatic runReq(input logic [31:0] o, input logic [31:0] r, input logic d,
                        output logic gf, output logic [4:0] gs, output int lat, output bit readyLeak);
    @(negedge clk);
    inValid = 1'b1; originalData = o; rotatedData = r; sel_left_or_right_rotate = d; outReady = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0; originalData = $urandom; rotatedData = $urandom;
    sel_left_or_right_rotate = ~d;
    lat = -1; readyLeak = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (inReady) readyLeak = 1'b1;
      if (outValid) begin lat = n; break; end
    end
    gf = found; gs = shiftVal;
    if (lat != -1) begin
      @(negedge clk); outReady = 1'b1;
      @(posedge clk); #1; outReady = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b0; sel_left_or_right_rotate = 1'b0;
    originalData = '0; rotatedData = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady: got %b expected 1", inReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid: got %b expected 0", outValid); end
    checks++; if (found !== 1'b0) begin errors++; $display("FAIL reset_found: got %b expected 0", found); end
    checks++; if (shiftVal !== 5'd0) begin errors++; $display("FAIL reset_shiftVal: got %0d expected 0", shiftVal); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] origT [7] = '{32'h0000_0001, 32'h1234_5678, 32'hAAAA_AAAA, 32'hAAAA_AAAA,
                               32'h0000_00FF, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [31:0] rotT  [7] = '{32'h8000_0000, 32'h2345_6781, 32'h5555_5555, 32'hAAAA_AAAA,
                               32'h0000_00FE, 32'h0000_0000, 32'hFFFF_FFFF};
    logic        dirT  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        fT    [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [4:0]  sT    [7] = '{5'd1, 5'd4, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0};
    logic gf; logic [4:0] gs; int lat; bit leak; int expLat;
    for (int i = 0; i < 7; i++) begin
      runReq(origT[i], rotT[i], dirT[i], gf, gs, lat, leak);
      expLat = (EARLY && fT[i]) ? int'(sT[i]) + 1 : 32;
      checks++; if (gf !== fT[i]) begin errors++; $display("FAIL directed%0d_found: got %b expected %b", i, gf, fT[i]); end
      checks++; if (gs !== sT[i]) begin errors++; $display("FAIL directed%0d_shiftVal: got %0d expected %0d", i, gs, sT[i]); end
      checks++; if (lat != expLat) begin errors++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, expLat); end
      checks++; if (leak) begin errors++; $display("FAIL directed%0d_inReady_busy: got 1 expected 0", i); end
    end
  endtask

  task automatic test_random();
    logic [31:0] o, r; logic d; int k; int mode;
    logic ef; logic [4:0] es; int elat;
    logic gf; logic [4:0] gs; int lat; bit leak;
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      d = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 31);
      o = $urandom;
      if (mode == 2) o = {4{o[7:0]}};
      r = (mode == 0) ? 32'($urandom) : modelRot(o, k, d);
      modelFind(o, r, d, ef, es, elat);
      runReq(o, r, d, gf, gs, lat, leak);
      checks++; if (gf !== ef) begin errors++; $display("FAIL random%0d_found: got %b expected %b", i, gf, ef); end
      checks++; if (gs !== es) begin errors++; $display("FAIL random%0d_shiftVal: got %0d expected %0d", i, gs, es); end
      checks++; if (lat != elat) begin errors++; $display("FAIL random%0d_latency: got %0d expected %0d", i, lat, elat); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] o, r; int lat; int expLat;
    o = 32'h0000_0003;
    r = modelRot(o, 20, 1'b0);
    expLat = EARLY ? 21 : 32;
    @(negedge clk);
    inValid = 1'b1; originalData = o; rotatedData = r; sel_left_or_right_rotate = 1'b0; outReady = 1'b0;
    @(posedge clk); #1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      // These pulses carry a shift-0 match that must not be accepted.
      inValid = (n <= 5);
      originalData = r; rotatedData = r; sel_left_or_right_rotate = 1'b1;
      @(posedge clk); #1;
      if (n <= 5) begin
        checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL stall_search_inReady%0d: got %b expected 0", n, inReady); end
      end
      if (outValid) begin lat = n; break; end
    end
    inValid = 1'b0;
    checks++; if (lat != expLat) begin errors++; $display("FAIL stall_latency: got %0d expected %0d", lat, expLat); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (outValid !== 1'b1 || found !== 1'b1 || shiftVal !== 5'd20 || inReady !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: got outValid=%b found=%b shiftVal=%0d inReady=%b expected 1 1 20 0",
                 c, outValid, found, shiftVal, inReady);
      end
    end
    @(negedge clk); outReady = 1'b1;
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL handshake_cycle_inReady: got %b expected 0", inReady); end
    @(posedge clk); #1; outReady = 1'b0;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL after_handshake_outValid: got %b expected 0", outValid); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL after_handshake_inReady: got %b expected 1", inReady); end
  endtask

  task automatic test_reset_mid();
    bit sawValid; logic gf; logic [4:0] gs; int lat; bit leak; int expLat;
    @(negedge clk);
    inValid = 1'b1; originalData = 32'h0000_00FF; rotatedData = 32'h0000_00FE;
    sel_left_or_right_rotate = 1'b0; outReady = 1'b1;
    @(posedge clk); #1; inValid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL midreset_inReady: got %b expected 1", inReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL midreset_outValid: got %b expected 0", outValid); end
    checks++; if (found !== 1'b0 || shiftVal !== 5'd0) begin errors++; $display("FAIL midreset_result: got found=%b shiftVal=%0d expected 0 0", found, shiftVal); end
    @(negedge clk); rst_n = 1'b1;
    sawValid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (outValid) sawValid = 1'b1;
    end
    checks++; if (sawValid) begin errors++; $display("FAIL midreset_no_result: got outValid=1 expected 0"); end
    outReady = 1'b0;
    runReq(32'h0000_0001, 32'h8000_0000, 1'b1, gf, gs, lat, leak);
    expLat = EARLY ? 2 : 32;
    checks++; if (gf !== 1'b1 || gs !== 5'd1) begin errors++; $display("FAIL postreset_result: got found=%b shiftVal=%0d expected 1 1", gf, gs); end
    checks++; if (lat != expLat) begin errors++; $display("FAIL postreset_latency: got %0d expected %0d", lat, expLat); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
